// File: rtl/registers.sv
// Register file for the single-cycle datapath: 2^ADDR_WIDTH words of DATA_WIDTH bits,
// two combinational read ports and one synchronous write port. Register 0 has no
// storage and always reads zero.
module registers #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rna,
  input  logic [ADDR_WIDTH-1:0] rnb,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] wn,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Storage exists only for r1..r(Depth-1); r0 is synthesised away entirely.
  logic [DATA_WIDTH-1:0] regs_q [1:Depth-1];
  logic [Depth-1:1]      wr_en;

  // Decode the write port into one enable per stored register; wn == 0 selects nothing.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 1; i < Depth; i++) begin
      if (write && (wn == ADDR_WIDTH'(i))) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  for (genvar gi = 1; gi < Depth; gi++) begin : g_reg
    // Each register clears asynchronously on reset and loads wd on its write enable.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs_q[gi] <= '0;
      end else if (wr_en[gi]) begin
        regs_q[gi] <= wd;
      end
    end
  end

  // Read ports: plain muxes, no bypass from the write port; address 0 falls through to zero.
  always_comb begin
    A = '0;
    B = '0;
    for (int unsigned i = 1; i < Depth; i++) begin
      if (rna == ADDR_WIDTH'(i)) begin
        A = regs_q[i];
      end
      if (rnb == ADDR_WIDTH'(i)) begin
        B = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register file: stimulus pushes expected A/B values and
// raises an event; a separate monitor samples the ports and compares.
module tb_registers;

  logic        clk;
  logic        reset;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] wd;
  logic [4:0]  wn;
  logic        write;
  logic [31:0] A;
  logic [31:0] B;

  registers #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rna  (rna),
    .rnb  (rnb),
    .wd   (wd),
    .wn   (wn),
    .write(write),
    .A    (A),
    .B    (B)
  );

  typedef struct {
    string       name;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each sample request, pop expectations and compare against the ports.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (A !== e.exp_a) begin
          n_fail++;
          $display("FAIL %s port A: got %08h expected %08h", e.name, A, e.exp_a);
        end
        n_cmp++;
        if (B !== e.exp_b) begin
          n_fail++;
          $display("FAIL %s port B: got %08h expected %08h", e.name, B, e.exp_b);
        end
      end
    end
  end

  // Let combinational reads settle, queue the expectation, ask the monitor to sample.
  task automatic expect_ab(input string name, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    #1;
    e.name  = name;
    e.exp_a = ea;
    e.exp_b = eb;
    sb_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1;
    wn    = n;
    wd    = d;
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    write = 1'b0;
    wn    = '0;
    wd    = '0;
    rna   = 5'd1;
    rnb   = 5'd2;

    // Asynchronous reset before any clock edge.
    #2;
    reset = 1'b1;
    expect_ab("reset_no_clock", 32'h0, 32'h0);

    // Writes are ignored while reset is held.
    write = 1'b1;
    wn    = 5'd5;
    wd    = 32'hFFFF_FFFF;
    rna   = 5'd5;
    rnb   = 5'd5;
    repeat (2) @(posedge clk);
    expect_ab("write_during_reset", 32'h0, 32'h0);

    // Release reset; the write lands on the next rising edge, not before.
    @(negedge clk);
    reset = 1'b0;
    expect_ab("r5_before_edge", 32'h0, 32'h0);
    @(posedge clk);
    expect_ab("r5_after_edge", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    write = 1'b0;

    write_reg(5'd3, 32'h1234_5678);

    // No bypass: reading r31 while it is being written shows the old value.
    @(negedge clk);
    write = 1'b1;
    wn    = 5'd31;
    wd    = 32'hCAFE_BABE;
    rna   = 5'd31;
    rnb   = 5'd3;
    expect_ab("r31_no_bypass", 32'h0, 32'h1234_5678);
    @(posedge clk);
    expect_ab("r31_after_edge", 32'hCAFE_BABE, 32'h1234_5678);
    @(negedge clk);
    write = 1'b0;

    rna = 5'd3;
    rnb = 5'd31;
    expect_ab("r3_r31", 32'h1234_5678, 32'hCAFE_BABE);
    rna = 5'd31;
    expect_ab("same_addr", 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Writes to r0 are dropped and disturb nothing else.
    write_reg(5'd0, 32'hDEAD_BEEF);
    rna = 5'd0;
    rnb = 5'd5;
    expect_ab("r0_write_ignored", 32'h0, 32'hFFFF_FFFF);
    rnb = 5'd0;
    expect_ab("r0_both_ports", 32'h0, 32'h0);

    // write == 0 holds contents across several edges.
    write = 1'b0;
    wn    = 5'd3;
    wd    = 32'h0;
    repeat (3) @(posedge clk);
    rna = 5'd3;
    rnb = 5'd31;
    expect_ab("hold_no_write", 32'h1234_5678, 32'hCAFE_BABE);

    // Overwrite an existing register.
    write_reg(5'd3, 32'hA5A5_0F0F);
    rna = 5'd3;
    rnb = 5'd5;
    expect_ab("r3_overwrite", 32'hA5A5_0F0F, 32'hFFFF_FFFF);

    // Reset mid-cycle with a pending write: outputs drop at once, write is lost.
    @(negedge clk);
    write = 1'b1;
    wn    = 5'd7;
    wd    = 32'h5555_AAAA;
    rna   = 5'd3;
    rnb   = 5'd31;
    #2;
    reset = 1'b1;
    expect_ab("async_reset_mid", 32'h0, 32'h0);
    write = 1'b0;
    #1;
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rna = 5'(i);
      rnb = 5'(32 - i);
      expect_ab($sformatf("cleared_r%0d", i), 32'h0, 32'h0);
    end

    // First write after reset release.
    write_reg(5'd7, 32'h0BAD_F00D);
    rna = 5'd7;
    rnb = 5'd5;
    expect_ab("write_after_reset", 32'h0BAD_F00D, 32'h0);

    // Bounded drain of the scoreboard.
    waited = 0;
    while (sb_q.size() > 0 && waited < 100) begin
      #1;
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/registers.md
# registers

General-purpose register file for the single-cycle CPU datapath: 32 registers of 32 bits, two asynchronous read ports (A, B) and one synchronous write port. It sits between instruction decode, which supplies the rs/rt/rd register numbers, and the ALU/writeback path. Register 0 is hardwired to zero, following the MIPS convention.

## Interface
- DATA_WIDTH, 32, width of each register and of wd/A/B (fixed at 32 for this design)
- ADDR_WIDTH, 5, width of the register-number ports; depth is 2^ADDR_WIDTH = 32
- clk  input  1  clock; all writes occur on the rising edge
- reset  input  1  asynchronous, active-high; clears every register to 0
- rna  input  5  read-port A register number
- rnb  input  5  read-port B register number
- wd  input  32  write data
- wn  input  5  write register number
- write  input  1  write enable, active-high, sampled on the rising edge of clk
- A  output  32  contents of register rna (combinational)
- B  output  32  contents of register rnb (combinational)

## Operation
- Storage: registers r1..r31, 32 bits each. r0 has no storage and always reads 0.
- Read:
  - A = (rna == 0) ? 0 : r[rna]
  - B = (rnb == 0) ? 0 : r[rnb]
  - Both reads are purely combinational and independent; rna == rnb is legal, and both outputs then show the same value.
- Write:
  - On the rising edge of clk, if reset == 0, write == 1 and wn != 0, then r[wn] <= wd.
  - A write with wn == 0 is ignored.
  - With write == 0, all registers hold their values.
- Reset:
  - While reset == 1, all registers are 0 regardless of clk.
  - A and B therefore read 0 for every address.
  - Reset overrides a coincident write.
  - Releasing reset needs no clock; the first write can land on the next rising edge.
- There is no read-during-write bypass: a read of wn in the same cycle as a write returns the old value until the edge, then the new value.

## Timing
- Read latency: zero cycles (combinational from rna/rnb and register contents).
- Write latency: one edge. The new value is visible on A/B immediately after the rising edge that captures it.
- Reset asserts asynchronously. After reset is asserted, A and B read 0 with no clock edge.
- If reset asserts mid-cycle, any pending write is lost.
- wd, wn and write must be stable around the rising edge of clk.
- X or undefined inputs are not defined behaviour; the bench must drive known values.

## Test plan
- Assert reset=1 with rna=1, rnb=2 and no clock edge -> A=0, B=0 immediately. Then toggle clk with write=1, wn=5, wd=32'hFFFFFFFF while reset stays 1, and set rna=5 -> A remains 0.
- Deassert reset; drive write=1, wn=5, wd=32'hFFFFFFFF, rna=5 -> A=0 before the rising edge, A=32'hFFFFFFFF after it.
- Write 32'h12345678 to r3 and 32'hCAFEBABE to r31; set rna=3, rnb=31 -> A=32'h12345678, B=32'hCAFEBABE. Set rna=rnb=31 -> A=B=32'hCAFEBABE.
- Drive write=1, wn=0, wd=32'hDEADBEEF, then clock; set rna=0 -> A=0.
- Drive write=0, wn=3, wd=32'h0 across several edges -> r3 still reads 32'h12345678.
- With registers loaded, assert reset between clock edges -> A and B drop to 0 asynchronously. Deassert reset -> all of r1..r31 read 0.
